// File: rtl/vdcm_pkg.sv
// Shared constants, FSM state type and round-robin helper for the substream word demux.
package vdcm_pkg;

    localparam int SSM_NUM    = 4;
    localparam int MUX_WORD_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } demux_state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
        int unsigned nxt;
        if (idx + 32'd1 >= num) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ssm_word_fifo.sv
// Show-ahead FIFO for one substream: the head entry is always presented on data while vld.
// Pops on an empty FIFO are ignored and reported on the underflow pulse.
module ssm_word_fifo
    import vdcm_pkg::*;
#(
    parameter int WORD_W = MUX_WORD_W,
    parameter int DEPTH  = 2,
    parameter int OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] data,
    output logic              vld,
    output logic [OCC_W-1:0]  occ,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [OCC_W-1:0]  occ_r;
    logic              pop_ok_s;

    assign vld       = (occ_r != {OCC_W{1'b0}});
    assign pop_ok_s  = pop & vld;
    assign underflow = pop & ~vld;
    assign occ       = occ_r;
    assign data      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; a write into a full FIFO is legal only alongside a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            occ_r <= occ_r + OCC_W'(push) - OCC_W'(pop_ok_s);
        end
    end

endmodule

// File: rtl/ssm_word_demux.sv
// Routes rate-buffer words to per-substream FIFOs: sequential prime fill, then round-robin refill.
// Optional per-substream word counters are built when SSM_DEMUX_STATS_EN is defined.
module ssm_word_demux
    import vdcm_pkg::*;
#(
    parameter int NUM_SSM   = SSM_NUM,
    parameter int WORD_W    = MUX_WORD_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_dec,
    input  logic                      in_valid,
    input  logic [WORD_W-1:0]         in_data,
    output logic                      in_ready,
    input  logic [NUM_SSM-1:0]        ssm_rd_en,
    output logic [NUM_SSM*WORD_W-1:0] ssm_data,
    output logic [NUM_SSM-1:0]        ssm_vld,
    output logic                      prime_done,
    output logic                      underflow,
    output logic [NUM_SSM*16-1:0]     word_cnt
);

    localparam int IDX_W       = (NUM_SSM > 1) ? $clog2(NUM_SSM) : 1;
    localparam int PTR_W       = $clog2(BUF_DEPTH);
    localparam int OCC_W       = PTR_W + 1;
    localparam int PRIME_WORDS = NUM_SSM * BUF_DEPTH;
    localparam int PCNT_W      = $clog2(PRIME_WORDS);

    demux_state_t      state_r;
    demux_state_t      state_next_s;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [PCNT_W-1:0] prime_cnt_r;
    logic              prime_done_r;
    logic              underflow_r;

    logic [NUM_SSM-1:0] vld_s;
    logic [NUM_SSM-1:0] uf_s;
    logic [NUM_SSM-1:0] req_s;
    logic [NUM_SSM-1:0] push_s;
    logic [OCC_W-1:0]   occ_s [NUM_SSM];
    logic [IDX_W-1:0]   grant_s;
    logic               grant_vld_s;
    logic [IDX_W-1:0]   prime_tgt_s;
    logic [IDX_W-1:0]   tgt_s;
    logic               prime_last_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               flush_s;

    assign flush_s      = ~start_dec;
    assign prime_tgt_s  = IDX_W'(prime_cnt_r >> PTR_W);
    assign prime_last_s = (prime_cnt_r == PCNT_W'(PRIME_WORDS - 1));
    assign accept_s     = in_valid & in_ready_s;
    assign tgt_s        = (state_r == PRIME) ? prime_tgt_s : grant_s;

    // Space-after-pop request per substream; a pop counts only when the FIFO holds data.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_SSM; i++) begin
            req_s[i] = ((occ_s[i] - OCC_W'(ssm_rd_en[i] & vld_s[i])) < OCC_W'(BUF_DEPTH));
        end
    end

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_s     = '0;
        grant_vld_s = 1'b0;
        for (int k = 0; k < NUM_SSM; k++) begin
            if (!grant_vld_s && req_s[IDX_W'((int'(rr_ptr_r) + k) % NUM_SSM)]) begin
                grant_s     = IDX_W'((int'(rr_ptr_r) + k) % NUM_SSM);
                grant_vld_s = 1'b1;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Next state and ready; ready never looks at in_valid.
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_dec) begin
                    state_next_s = PRIME;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRIME: begin
                in_ready_s = start_dec;
                if (!start_dec) begin
                    state_next_s = IDLE;
                end else if (accept_s && prime_last_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = PRIME;
                end
            end
            RUN: begin
                in_ready_s = start_dec & grant_vld_s;
                if (!start_dec) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
                in_ready_s   = 1'b0;
            end
        endcase
    end

    // One-hot write strobe for the FIFO selected by the prime counter or the arbiter.
    always_comb begin
        push_s = '0;
        for (int i = 0; i < NUM_SSM; i++) begin
            if (accept_s && (tgt_s == IDX_W'(i))) begin
                push_s[i] = 1'b1;
            end else begin
                push_s[i] = 1'b0;
            end
        end
    end

    // FSM, prime counter, round-robin pointer and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            rr_ptr_r     <= '0;
            prime_cnt_r  <= '0;
            prime_done_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            underflow_r <= underflow_r | (|uf_s);
            if (!start_dec) begin
                rr_ptr_r     <= '0;
                prime_cnt_r  <= '0;
                prime_done_r <= 1'b0;
            end else if (state_r == PRIME && accept_s) begin
                prime_cnt_r  <= prime_cnt_r + {{(PCNT_W-1){1'b0}}, 1'b1};
                prime_done_r <= prime_last_s;
            end else if (state_r == RUN && accept_s) begin
                rr_ptr_r <= IDX_W'(rr_next(32'(grant_s), 32'(NUM_SSM)));
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    for (genvar g = 0; g < NUM_SSM; g++) begin : g_fifo
        ssm_word_fifo #(
            .WORD_W (WORD_W),
            .DEPTH  (BUF_DEPTH),
            .OCC_W  (OCC_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush_s),
            .push      (push_s[g]),
            .push_data (in_data),
            .pop       (ssm_rd_en[g]),
            .data      (ssm_data[g*WORD_W +: WORD_W]),
            .vld       (vld_s[g]),
            .occ       (occ_s[g]),
            .underflow (uf_s[g])
        );
    end

`ifdef SSM_DEMUX_STATS_EN
    logic [15:0] cnt_r [NUM_SSM];

    // Per-substream written-word counters, wrapping, untouched by abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SSM; i++) begin
                cnt_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SSM; i++) begin
                if (push_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SSM; g++) begin : g_cnt
        assign word_cnt[g*16 +: 16] = cnt_r[g];
    end
`else
    assign word_cnt = '0;
`endif

    assign ssm_vld    = vld_s;
    assign in_ready   = in_ready_s;
    assign prime_done = prime_done_r;
    assign underflow  = underflow_r;

endmodule

// File: tb/tb_ssm_word_demux.sv
// Directed bench for ssm_word_demux: priming, round-robin refill, backpressure, underflow, abort, stats.
module tb_ssm_word_demux;

    localparam int NS = 4;
    localparam int WW = 128;

    logic             clk;
    logic             rst;
    logic             start_dec;
    logic             in_valid;
    logic [WW-1:0]    in_data;
    logic             in_ready;
    logic [NS-1:0]    ssm_rd_en;
    logic [NS*WW-1:0] ssm_data;
    logic [NS-1:0]    ssm_vld;
    logic             prime_done;
    logic             underflow;
    logic [NS*16-1:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [WW-1:0] W_A = 128'h0A0;
    localparam logic [WW-1:0] W_B = 128'h0B0;
    localparam logic [WW-1:0] W_C = 128'h0C0;
    localparam logic [WW-1:0] W_D = 128'h0D0;
    localparam logic [WW-1:0] W_E = 128'h0E0;
    localparam logic [WW-1:0] W_F = 128'h0F0;
    localparam logic [WW-1:0] W_G = 128'h111;
    localparam logic [WW-1:0] W_H = 128'h055;

    ssm_word_demux #(.NUM_SSM(NS), .WORD_W(WW), .BUF_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_dec  (start_dec),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ssm_rd_en  (ssm_rd_en),
        .ssm_data   (ssm_data),
        .ssm_vld    (ssm_vld),
        .prime_done (prime_done),
        .underflow  (underflow),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WW-1:0] head(input int i);
        return ssm_data[i*WW +: WW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        #1;
        while (in_ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (n >= 10) begin
            failures++;
            $display("FAIL send_timeout word=%0h in_ready never rose within 10 cycles", w);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_dec = 1'b0; in_valid = 1'b0; in_data = '0; ssm_rd_en = '0;
        repeat (3) step();
        checks++;
        if (ssm_data !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", ssm_data); end
        checks++;
        if (ssm_vld !== 4'b0000) begin failures++; $display("FAIL reset_vld got=%b exp=0000", ssm_vld); end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
        checks++;
        if (prime_done !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b exp=00", prime_done, underflow);
        end
        checks++;
        if (word_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", word_cnt); end
    endtask

    task automatic test_prime();
        start_dec = 1'b1;
        for (int w = 0; w < 8; w++) begin
            send_word(WW'(w));
            if (w == 2) begin
                checks++;
                if (ssm_vld !== 4'b0011) begin failures++; $display("FAIL prime_order got=%b exp=0011", ssm_vld); end
            end else if (w == 6) begin
                checks++;
                if (prime_done !== 1'b0) begin failures++; $display("FAIL prime_early got=%b exp=0", prime_done); end
            end
        end
        checks++;
        if (prime_done !== 1'b1) begin failures++; $display("FAIL prime_done got=%b exp=1", prime_done); end
        checks++;
        if (ssm_vld !== 4'b1111) begin failures++; $display("FAIL prime_vld got=%b exp=1111", ssm_vld); end
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (head(i) !== WW'(2 * i)) begin
                failures++; $display("FAIL prime_head%0d got=%0h exp=%0h", i, head(i), 2 * i);
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL prime_full_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_rr_order();
        in_valid = 1'b1; in_data = W_A; ssm_rd_en = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rr_ready_a got=%b exp=1", in_ready); end
        step();
        in_data = W_B; ssm_rd_en = 4'b0001;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rr_ready_b got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0; ssm_rd_en = '0;
        checks++;
        if (head(0) !== WW'(1) || head(2) !== WW'(5)) begin
            failures++; $display("FAIL rr_heads got=%0h,%0h exp=1,5", head(0), head(2));
        end
        ssm_rd_en = 4'b0101;
        step();
        ssm_rd_en = '0;
        checks++;
        if (head(0) !== W_B || head(2) !== W_A) begin
            failures++; $display("FAIL rr_order got=%0h,%0h exp=%0h,%0h", head(0), head(2), W_B, W_A);
        end
    endtask

    task automatic test_rr_ptr();
        in_valid = 1'b1; in_data = W_D;
        step();
        in_data = W_E;
        step();
        in_valid = 1'b0;
        ssm_rd_en = 4'b0100;
        step();
        checks++;
        if (head(2) !== W_D) begin failures++; $display("FAIL rrptr_d got=%0h exp=%0h", head(2), W_D); end
        ssm_rd_en = 4'b0001;
        step();
        ssm_rd_en = '0;
        checks++;
        if (head(0) !== W_E) begin failures++; $display("FAIL rrptr_e got=%0h exp=%0h", head(0), W_E); end
        in_valid = 1'b1; in_data = W_F;
        step();
        in_data = W_G;
        step();
        in_valid = 1'b0;
        checks++;
        if (ssm_vld !== 4'b1111) begin failures++; $display("FAIL rrptr_refill got=%b exp=1111", ssm_vld); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = W_C; ssm_rd_en = '0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        step();
        ssm_rd_en = 4'b1000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_pop_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0; ssm_rd_en = '0;
        checks++;
        if (head(3) !== WW'(7) || ssm_vld !== 4'b1111) begin
            failures++; $display("FAIL bp_head3 got=%0h vld=%b exp=7 vld=1111", head(3), ssm_vld);
        end
        ssm_rd_en = 4'b1000;
        step();
        ssm_rd_en = '0;
        checks++;
        if (head(3) !== W_C) begin failures++; $display("FAIL bp_landed got=%0h exp=%0h", head(3), W_C); end
    endtask

    task automatic test_underflow();
        ssm_rd_en = 4'b0010;
        step();
        checks++;
        if (head(1) !== WW'(3)) begin failures++; $display("FAIL uf_head1 got=%0h exp=3", head(1)); end
        step();
        checks++;
        if (ssm_vld[1] !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL uf_empty got vld1=%b uf=%b exp 0,0", ssm_vld[1], underflow);
        end
        step();
        checks++;
        if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", underflow); end
        ssm_rd_en = '0;
        step();
        checks++;
        if (underflow !== 1'b1 || ssm_vld[1] !== 1'b0) begin
            failures++; $display("FAIL uf_sticky got uf=%b vld1=%b exp 1,0", underflow, ssm_vld[1]);
        end
    endtask

    task automatic test_abort();
        start_dec = 1'b0;
        step();
        checks++;
        if (ssm_vld !== 4'b0000 || prime_done !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort got vld=%b pd=%b rdy=%b exp 0000,0,0", ssm_vld, prime_done, in_ready);
        end
        checks++;
        if (underflow !== 1'b1) begin failures++; $display("FAIL abort_uf_held got=%b exp=1", underflow); end
        start_dec = 1'b1;
        send_word(W_H);
        checks++;
        if (ssm_vld !== 4'b0001 || head(0) !== W_H || prime_done !== 1'b0) begin
            failures++;
            $display("FAIL restart got vld=%b h0=%0h pd=%b exp 0001,%0h,0", ssm_vld, head(0), prime_done, W_H);
        end
    endtask

    task automatic test_word_cnt();
        logic [NS*16-1:0] exp_cnt;
`ifdef SSM_DEMUX_STATS_EN
        exp_cnt = {16'd3, 16'd5, 16'd2, 16'd6};
`else
        exp_cnt = '0;
`endif
        checks++;
        if (word_cnt !== exp_cnt) begin
            failures++; $display("FAIL word_cnt got=%0h exp=%0h", word_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_rr_order();
        test_rr_ptr();
        test_backpressure();
        test_underflow();
        test_abort();
        test_word_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
